// File: rtl/router_pkg.sv
// router_pkg: shared types and constants for the input-router sequencers.
//   sched_state_t   - coordinate scheduler FSM states (IDLE, RUN, DONE)
//   KERNEL_SIZE_DEF - default depthwise kernel edge length
//   STRIDE_1/2      - the legal stride encodings
package router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  localparam int KERNEL_SIZE_DEF = 3;

  localparam logic [1:0] STRIDE_1 = 2'd1;
  localparam logic [1:0] STRIDE_2 = 2'd2;

endpackage

// File: rtl/dw_coord_scheduler_if.sv
// dw_coord_scheduler_if: coordinate handshake bus from the scheduler to the
// 3x3 depthwise address generator.
//   o_valid  - coordinate valid (address generator i_en)
//   i_ready  - downstream accepts the current coordinate
//   o_o_x    - top-left input row coordinate
//   o_o_y    - top-left input column coordinate
//   o_row_id - one-hot destination PE row
// Member names are written from the scheduler's point of view.
interface dw_coord_scheduler_if #(
  parameter int ROWS       = 4,
  parameter int ADDR_WIDTH = 6
);
  logic                  o_valid;
  logic                  i_ready;
  logic [ADDR_WIDTH-1:0] o_o_x;
  logic [ADDR_WIDTH-1:0] o_o_y;
  logic [ROWS-1:0]       o_row_id;

  modport master (output o_valid, output o_o_x, output o_o_y, output o_row_id,
                  input  i_ready);
  modport slave  (input  o_valid, input  o_o_x, input  o_o_y, input  o_row_id,
                  output i_ready);
endinterface

// File: rtl/dw_coord_scheduler_coord_stepper.sv
// coord_stepper: combinational next-coordinate logic for a square raster walk.
//   i_x, i_y   - current top-left coordinate
//   i_limit    - largest legal coordinate (size - kernel)
//   i_stride   - step size
//   o_x, o_y   - next coordinate (y is the fast axis)
//   o_last     - current coordinate is the final one of the pass
// Sums are one bit wider than the coordinates so x/y + stride never wraps.
module coord_stepper #(
  parameter int ADDR_WIDTH = 6
) (
  input  logic [ADDR_WIDTH-1:0] i_x,
  input  logic [ADDR_WIDTH-1:0] i_y,
  input  logic [ADDR_WIDTH-1:0] i_limit,
  input  logic [1:0]            i_stride,
  output logic [ADDR_WIDTH-1:0] o_x,
  output logic [ADDR_WIDTH-1:0] o_y,
  output logic                  o_last
);
  logic [ADDR_WIDTH:0] sum_x;
  logic [ADDR_WIDTH:0] sum_y;
  logic [ADDR_WIDTH:0] limit_ext;

  assign sum_x     = {1'b0, i_x} + (ADDR_WIDTH+1)'(i_stride);
  assign sum_y     = {1'b0, i_y} + (ADDR_WIDTH+1)'(i_stride);
  assign limit_ext = {1'b0, i_limit};

  always_comb begin
    o_x    = i_x;
    o_y    = i_y;
    o_last = 1'b0;
    if (sum_y <= limit_ext) begin
      o_y = sum_y[ADDR_WIDTH-1:0];
    end else begin
      o_y = '0;
      if (sum_x <= limit_ext) begin
        o_x = sum_x[ADDR_WIDTH-1:0];
      end else begin
        o_last = 1'b1;
      end
    end
  end
endmodule

// File: rtl/dw_coord_scheduler.sv
// dw_coord_scheduler: walks the output feature map on i_start and issues one
// top-left input coordinate per accepted handshake, tagging each with a
// round-robin one-hot PE-row id.
//   i_clk, i_nrst    - clock, synchronous active-low reset
//   i_start          - start a pass (IDLE only)
//   i_reg_clear      - synchronous abort, same effect as reset
//   i_i_size         - square input map edge length, latched at start
//   i_stride         - stride (1 or 2), latched at start
//   cbus             - coordinate handshake bus (master side)
//   o_busy           - high while issuing coordinates
//   o_done / o_err   - end-of-pass pulse / illegal-config pulse
// Build option: DW_STRIDE2_EN enables the i_stride input; without it the
// stride is fixed at 1 and only an undersized map is flagged as an error.
module dw_coord_scheduler
  import router_pkg::*;
#(
  parameter int ROWS        = 4,
  parameter int ADDR_WIDTH  = 6,
  parameter int KERNEL_SIZE = KERNEL_SIZE_DEF
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_start,
  input  logic                  i_reg_clear,
  input  logic [ADDR_WIDTH-1:0] i_i_size,
  input  logic [1:0]            i_stride,
  dw_coord_scheduler_if.master  cbus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_err
);
  localparam logic [ADDR_WIDTH-1:0] K_W = ADDR_WIDTH'(KERNEL_SIZE);

  sched_state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] x_q, x_d, y_q, y_d, size_q, size_d;
  logic [1:0]            stride_q, stride_d;
  logic [ROWS-1:0]       row_q, row_d;
  logic                  valid_q, valid_d, busy_q, busy_d;
  logic                  done_q, done_d, err_q, err_d;

  logic [ADDR_WIDTH-1:0] limit, step_x, step_y;
  logic                  step_last;
  logic [1:0]            start_stride;
  logic                  cfg_bad;

`ifdef DW_STRIDE2_EN
  assign start_stride = i_stride;
  assign cfg_bad      = (i_i_size < K_W) ||
                        !((i_stride == STRIDE_1) || (i_stride == STRIDE_2));
`else
  logic [1:0] unused_stride;
  assign unused_stride = i_stride;
  assign start_stride  = STRIDE_1;
  assign cfg_bad       = (i_i_size < K_W);
`endif

  // Only meaningful in RUN, where size_q >= kernel is guaranteed.
  assign limit = size_q - K_W;

  coord_stepper #(.ADDR_WIDTH(ADDR_WIDTH)) u_stepper (
    .i_x      (x_q),
    .i_y      (y_q),
    .i_limit  (limit),
    .i_stride (stride_q),
    .o_x      (step_x),
    .o_y      (step_y),
    .o_last   (step_last)
  );

  always_comb begin
    state_d  = state_q;
    x_d      = x_q;
    y_d      = y_q;
    size_d   = size_q;
    stride_d = stride_q;
    row_d    = row_q;
    valid_d  = valid_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          size_d   = i_i_size;
          stride_d = start_stride;
          if (cfg_bad) begin
            state_d = DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = RUN;
            valid_d = 1'b1;
            busy_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
            row_d   = ROWS'(1);
          end
        end
      end
      RUN: begin
        if (valid_q && cbus.i_ready) begin
          if (step_last) begin
            state_d = DONE;
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            x_d     = '0;
            y_d     = '0;
            row_d   = '0;
          end else begin
            x_d   = step_x;
            y_d   = step_y;
            row_d = {row_q[ROWS-2:0], row_q[ROWS-1]};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_nrst || i_reg_clear) begin
      state_q  <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
      size_q   <= '0;
      stride_q <= '0;
      row_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      x_q      <= x_d;
      y_q      <= y_d;
      size_q   <= size_d;
      stride_q <= stride_d;
      row_q    <= row_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign cbus.o_valid  = valid_q;
  assign cbus.o_o_x    = x_q;
  assign cbus.o_o_y    = y_q;
  assign cbus.o_row_id = row_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_err         = err_q;
endmodule
